apb_cmd_sequencer: RTL and testbench
====================================

APB_CMD_SEQUENCER -- requirements
Module: apb_cmd_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning APB data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, meaning the maximum ACCESS-phase cycles waiting for PREADY (range 2..65535).
REQ-004 SHALL derive CMD_W = 1+ADDR_WIDTH+DATA_WIDTH and RSP_W = 2+DATA_WIDTH.
REQ-005 rclk  input  1  sole clock; all logic on its rising edge.
REQ-006 reset_n  input  1  reset, synchronous and active-low.
REQ-007 enable  input  1  allows new commands to be popped while high.
REQ-008 cmd_empty  input  1  command-FIFO registered empty flag.
REQ-009 cmd_ren  output  1  command-FIFO pop strobe.
REQ-010 cmd_rdata  input  CMD_W  command word {write, addr, wdata}, MSB first; valid the cycle after a pop (registered read).
REQ-011 rsp_full  input  1  response-FIFO full flag.
REQ-012 rsp_wen  output  1  response-FIFO push strobe.
REQ-013 rsp_wdata  output  RSP_W  response word {timeout, slverr, rdata}.
REQ-014 PSEL, PENABLE, PWRITE  output  1 each  APB control.
REQ-015 PADDR  output  ADDR_WIDTH; PWDATA  output  DATA_WIDTH; APB address and write data.
REQ-016 PRDATA  input  DATA_WIDTH; PREADY, PSLVERR  input  1 each; APB completer response.
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 done_cnt  output  16  count of completed transfers, including errored ones.

Function
REQ-019 FSM states SHALL be IDLE, LOAD, SETUP, ACCESS and RESP.
REQ-020 IDLE: cmd_ren = enable && !cmd_empty (combinational); if cmd_ren is high, next state is LOAD; otherwise the FSM stays in IDLE.
REQ-021 LOAD: the block captures cmd_rdata into PWRITE/PADDR/PWDATA (PWDATA forced to 0 for reads), sets PSEL=1 at the edge, and moves to SETUP.
REQ-022 SETUP: PSEL=1 and PENABLE=0 for exactly one cycle; PENABLE is set at the edge and the FSM moves to ACCESS.
REQ-023 ACCESS: PSEL=1 and PENABLE=1, with PADDR/PWRITE/PWDATA held stable; on PREADY=1 the block latches the result, clears PSEL/PENABLE at the same edge, and moves to RESP.
REQ-024 Result latch: rdata = PRDATA for reads and 0 for writes; slverr = PSLVERR; timeout = 0.
REQ-025 A 16-bit wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle with PREADY=0.
REQ-026 Timeout: when wait count reaches TIMEOUT_CYCLES-1 with PREADY=0, the block SHALL clear PSEL/PENABLE, latch {timeout=1, slverr=1, rdata=0}, and go to RESP.
REQ-027 PREADY=1 on the same cycle as the timeout condition SHALL win, giving a normal completion.
REQ-028 RESP: rsp_wen = !rsp_full (combinational) and rsp_wdata = the latched result; when rsp_wen is high, done_cnt increments (wrapping at 16 bits) and the FSM goes to IDLE; otherwise it stalls in RESP.
REQ-029 cmd_ren SHALL never assert outside IDLE, so at most one command is in flight.
REQ-030 rsp_wen SHALL never assert while rsp_full=1.
REQ-031 Zero-wait throughput SHALL be 5 cycles per transfer; latency from the cmd_ren cycle to the first SETUP cycle is 2 cycles.
REQ-032 enable deasserting mid-transfer SHALL NOT abort; the current transfer completes through RESP, then the FSM holds in IDLE.
REQ-033 PSEL SHALL remain low in RESP and IDLE, with no back-to-back transfer without an idle gap.

Reset
REQ-034 reset_n=0 at an rclk edge SHALL force state IDLE; PSEL, PENABLE and PWRITE = 0; PADDR, PWDATA, result latch, wait counter and done_cnt = 0.
REQ-035 Combinational outputs under reset: cmd_ren=0 and rsp_wen=0 while reset_n=0.
REQ-036 Reset mid-transfer SHALL abort at the next edge; the popped command is discarded and no response is produced.

Verification
REQ-037 Write cmd {1, 0x0000_1000, 0xDEAD_BEEF} with PREADY tied 1 -> SETUP then ACCESS with PADDR=0x1000 and PWDATA=0xDEADBEEF; rsp_wdata = {0,0,0x0}; done_cnt=1; 5 cycles total.
REQ-038 Read cmd at 0x24 with PREADY low for 3 ACCESS cycles and PRDATA=0x1234_5678 -> PSEL high for 5 cycles, signals stable throughout; rsp_wdata = {0,0,0x12345678}.
REQ-039 PSLVERR=1 with PREADY on a write -> rsp_wdata = {0,1,0x0}.
REQ-040 TIMEOUT_CYCLES=4 with PREADY held 0 -> 4 ACCESS cycles, then PSEL drops; rsp_wdata = {1,1,0x0}; the next command proceeds normally.
REQ-041 rsp_full=1 during RESP for 10 cycles -> rsp_wen=0, FSM held in RESP, cmd_ren=0; on rsp_full falling, exactly one push occurs.
REQ-042 reset_n pulsed low during ACCESS -> next cycle all outputs at reset values, no rsp_wen, done_cnt=0; three queued commands then complete in order.

Source files
------------

// File: rtl/apb_cmd_sequencer_if.sv
// apb_cmd_sequencer_if: APB requester/completer signal bundle
interface apb_cmd_sequencer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA, PRDATA;
  modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, input PRDATA, PREADY, PSLVERR);
  modport slave  (input PSEL, PENABLE, PWRITE, PADDR, PWDATA, output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/apb_cmd_sequencer.sv
// apb_cmd_sequencer: pops {write, addr, wdata} commands, runs one APB transfer each, pushes {timeout, slverr, rdata}
module apb_cmd_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int CMD_W = 1 + ADDR_WIDTH + DATA_WIDTH,
  localparam int RSP_W = 2 + DATA_WIDTH
) (
  input  logic                 rclk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 cmd_empty,
  output logic                 cmd_ren,
  input  logic [CMD_W-1:0]     cmd_rdata,
  input  logic                 rsp_full,
  output logic                 rsp_wen,
  output logic [RSP_W-1:0]     rsp_wdata,
  apb_cmd_sequencer_if.master  apb,
  output logic                 busy,
  output logic [15:0]          done_cnt
);
  typedef enum logic [2:0] {IDLE, LOAD, SETUP, ACCESS, RESP} state_t;
  state_t state, state_nx;
  logic [15:0] wait_cnt;
  logic tmo;
  always_comb begin
    cmd_ren = reset_n && state == IDLE && enable && !cmd_empty;
    rsp_wen = reset_n && state == RESP && !rsp_full;
    tmo = !apb.PREADY && wait_cnt == 16'(TIMEOUT_CYCLES - 1);
    state_nx = state;
    case (state)
      IDLE:    state_nx = cmd_ren ? LOAD : IDLE;
      LOAD:    state_nx = SETUP;
      SETUP:   state_nx = ACCESS;
      ACCESS:  state_nx = (apb.PREADY || tmo) ? RESP : ACCESS;
      RESP:    state_nx = rsp_wen ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  assign busy = state != IDLE;
  // rsp_wdata doubles as the result latch; PREADY beats a coincident timeout
  always_ff @(posedge rclk) begin
    if (!reset_n) begin
      state       <= IDLE;
      apb.PSEL    <= 1'b0;
      apb.PENABLE <= 1'b0;
      apb.PWRITE  <= 1'b0;
      apb.PADDR   <= '0;
      apb.PWDATA  <= '0;
      rsp_wdata   <= '0;
      wait_cnt    <= '0;
      done_cnt    <= '0;
    end else begin
      state <= state_nx;
      if (state == LOAD) begin
        apb.PWRITE <= cmd_rdata[CMD_W-1];
        apb.PADDR  <= cmd_rdata[DATA_WIDTH +: ADDR_WIDTH];
        apb.PWDATA <= cmd_rdata[CMD_W-1] ? cmd_rdata[DATA_WIDTH-1:0] : '0;
        apb.PSEL   <= 1'b1;
      end
      if (state == SETUP) begin
        apb.PENABLE <= 1'b1;
        wait_cnt    <= '0;
      end
      if (state == ACCESS) begin
        if (apb.PREADY) rsp_wdata <= {1'b0, apb.PSLVERR, apb.PWRITE ? {DATA_WIDTH{1'b0}} : apb.PRDATA};
        else if (tmo) rsp_wdata <= {2'b11, {DATA_WIDTH{1'b0}}};
        else wait_cnt <= wait_cnt + 16'd1;
        if (state_nx == RESP) begin
          apb.PSEL    <= 1'b0;
          apb.PENABLE <= 1'b0;
        end
      end
      if (rsp_wen) done_cnt <= done_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// tb_apb_cmd_sequencer: directed and random transfers scored against a per-command response model
module tb_apb_cmd_sequencer;
  localparam int AW = 32, DW = 32, T = 4, CMD_W = 1 + AW + DW, RSP_W = 2 + DW;
  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [DW-1:0] rd;
    logic          err;
    int            wt;
  } cmd_t;
  logic rclk = 0, reset_n = 0, enable = 0, cmd_empty = 1, rsp_full = 0;
  logic cmd_ren, rsp_wen, busy;
  logic [CMD_W-1:0] cmd_rdata = '0;
  logic [RSP_W-1:0] rsp_wdata;
  logic [15:0] done_cnt;
  int errors = 0, checks = 0, cyc = 0, exp_done = 0, acc = 0, psel_n = 0, setup_n = 0;
  logic in_acc = 0;
  logic [CMD_W-1:0] cmd_q[$];
  cmd_t apb_q[$];
  logic [RSP_W-1:0] exp_q[$];
  int ren_t[$], wen_t[$];

  apb_cmd_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb();

  apb_cmd_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)) dut (
    .rclk(rclk), .reset_n(reset_n), .enable(enable), .cmd_empty(cmd_empty),
    .cmd_ren(cmd_ren), .cmd_rdata(cmd_rdata), .rsp_full(rsp_full), .rsp_wen(rsp_wen),
    .rsp_wdata(rsp_wdata), .apb(apb), .busy(busy), .done_cnt(done_cnt)
  );

  always #5 rclk = ~rclk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_acc(int wt);
    return wt <= T - 1 ? wt + 1 : T;
  endfunction

  task automatic push(logic wr, logic [AW-1:0] addr, logic [DW-1:0] wd, logic [DW-1:0] rd, logic err, int wt);
    cmd_t c = '{wr, addr, wd, rd, err, wt};
    cmd_q.push_back({wr, addr, wd});
    apb_q.push_back(c);
    exp_q.push_back(wt <= T - 1 ? {1'b0, err, wr ? 32'h0 : rd} : {2'b11, 32'h0});
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge rclk);
      #1;
    end
  endtask

  task automatic wait_done(int n);
    int k = 0;
    while ((exp_done < n || busy) && k < 3000) begin
      tick();
      k++;
    end
    chk("wait_done", k < 3000, 1);
  endtask

  // command FIFO with registered read data and registered empty flag
  always @(posedge rclk) begin
    cyc++;
    if (cmd_ren && cmd_q.size() > 0) cmd_rdata <= cmd_q.pop_front();
    cmd_empty <= cmd_q.size() == 0;
  end

  // monitor, response scoreboard and APB completer
  always @(negedge rclk) begin
    if (cmd_ren) begin
      ren_t.push_back(cyc);
      chk("ren_ok", {enable, busy}, 2'b10);
    end
    if (rsp_wen) begin
      wen_t.push_back(cyc);
      chk("wen_full", rsp_full, 0);
      if (exp_q.size() == 0) chk("rsp_extra", exp_q.size(), 1);
      else chk("rsp", rsp_wdata, exp_q.pop_front());
      exp_done++;
    end
    if (apb.PSEL) begin
      if (apb_q.size() == 0) chk("psel_extra", apb_q.size(), 1);
      else begin
        chk("paddr", apb.PADDR, apb_q[0].addr);
        chk("pwrite", apb.PWRITE, apb_q[0].wr);
        chk("pwdata", apb.PWDATA, apb_q[0].wr ? apb_q[0].wd : 32'h0);
      end
      psel_n++;
      if (!apb.PENABLE && ren_t.size() > 0) begin
        setup_n++;
        chk("setup_lat", cyc - ren_t[$], 2);
      end
    end
    if (reset_n && apb.PSEL && apb.PENABLE && apb_q.size() > 0) begin
      in_acc = 1;
      apb.PREADY  = acc == apb_q[0].wt;
      apb.PSLVERR = acc == apb_q[0].wt ? apb_q[0].err : 1'($urandom_range(0, 1));
      apb.PRDATA  = acc == apb_q[0].wt ? apb_q[0].rd : $urandom;
      acc++;
    end else begin
      apb.PREADY  = 0;
      apb.PSLVERR = 1'($urandom_range(0, 1));
      apb.PRDATA  = $urandom;
      if (reset_n && !apb.PSEL && in_acc) begin
        chk("acc_cycles", acc, exp_acc(apb_q[0].wt));
        chk("psel_cycles", psel_n, acc + 1);
        chk("setup_cycles", setup_n, 1);
        void'(apb_q.pop_front());
        in_acc = 0; acc = 0; psel_n = 0; setup_n = 0;
      end
    end
    if (!reset_n) begin
      in_acc = 0; acc = 0; psel_n = 0; setup_n = 0;
    end
  end

  initial begin
    logic [15:0] d0;
    int p0, k;
    enable = 1;
    push(1, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0, 0, 0);
    tick(3);
    chk("rst_cmd_ren", cmd_ren, 0);
    chk("rst_rsp_wen", rsp_wen, 0);
    chk("rst_busy", busy, 0);
    chk("rst_psel", apb.PSEL, 0);
    chk("rst_penable", apb.PENABLE, 0);
    chk("rst_pwrite", apb.PWRITE, 0);
    chk("rst_paddr", apb.PADDR, 0);
    chk("rst_pwdata", apb.PWDATA, 0);
    chk("rst_rsp", rsp_wdata, 0);
    chk("rst_done", done_cnt, 0);
    // zero-wait writes back to back: latency and throughput
    ren_t.delete(); wen_t.delete();
    push(1, 32'h0000_1004, 32'h0BAD_F00D, 32'h0, 0, 0);
    reset_n = 1;
    wait_done(2);
    chk("tput", ren_t[1] - ren_t[0], 5);
    chk("resp_lat", wen_t[0] - ren_t[0], 4);
    chk("done2", done_cnt, 2);
    // read with three wait states, then slave error on a write
    push(0, 32'h24, $urandom, 32'h1234_5678, 0, 3);
    wait_done(3);
    push(1, 32'h2000, 32'hCAFE_F00D, $urandom, 1, 0);
    wait_done(4);
    chk("done4", done_cnt, 4);
    // timeout, PREADY on the timeout cycle, then a normal errored read
    push(1, 32'h3000, 32'h1, 32'h0, 0, 9);
    push(0, 32'h3004, 32'h0, 32'hA5A5_A5A5, 0, 3);
    push(0, 32'h3008, 32'h0, 32'h5A5A_5A5A, 1, 2);
    wait_done(7);
    // response FIFO full stall
    rsp_full = 1;
    d0 = done_cnt;
    p0 = exp_done;
    push(0, 32'h4000, 32'h0, 32'h0000_55AA, 0, 1);
    push(1, 32'h4004, 32'h1357_9BDF, 32'h0, 0, 0);
    tick(15);
    chk("stall_busy", busy, 1);
    chk("stall_psel", apb.PSEL, 0);
    chk("stall_wen", rsp_wen, 0);
    chk("stall_ren", cmd_ren, 0);
    chk("stall_done", done_cnt, d0);
    rsp_full = 0;
    tick(3);
    chk("one_push", exp_done - p0, 1);
    chk("done_inc", done_cnt, d0 + 16'd1);
    wait_done(p0 + 2);
    // reset during ACCESS discards the transfer
    push(1, 32'h5000, 32'h77, 32'h0, 0, 6);
    k = 0;
    while (!(apb.PSEL && apb.PENABLE) && k < 50) begin
      tick();
      k++;
    end
    chk("reach_access", k < 50, 1);
    tick();
    reset_n = 0;
    tick();
    chk("abort_psel", apb.PSEL, 0);
    chk("abort_penable", apb.PENABLE, 0);
    chk("abort_pwrite", apb.PWRITE, 0);
    chk("abort_paddr", apb.PADDR, 0);
    chk("abort_busy", busy, 0);
    chk("abort_wen", rsp_wen, 0);
    chk("abort_done", done_cnt, 0);
    chk("abort_rsp", rsp_wdata, 0);
    void'(apb_q.pop_front());
    void'(exp_q.pop_front());
    exp_done = 0;
    reset_n = 1;
    push(0, 32'h6000, 32'h0, 32'h1111_1111, 0, 0);
    push(1, 32'h6004, 32'h2222_2222, 32'h0, 0, 1);
    push(0, 32'h6008, 32'h0, 32'h3333_3333, 1, 2);
    wait_done(3);
    chk("after_abort_done", done_cnt, 3);
    // random traffic with enable and rsp_full toggling
    p0 = exp_done;
    for (int i = 0; i < 40; i++) begin
      push(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 5));
      enable = $urandom_range(0, 3) != 0;
      rsp_full = $urandom_range(0, 2) == 0;
      tick($urandom_range(0, 6));
    end
    enable = 1;
    rsp_full = 0;
    wait_done(p0 + 40);
    chk("done_final", done_cnt, 16'(p0 + 40));
    chk("drain", exp_q.size() + apb_q.size() + cmd_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
